// File: rtl/and8bit_arbiter.sv
// Two-port arbiter sharing one and8bit datapath. Accept-to-rsp_valid latency is 2 cycles.
// RESP holds the result while rsp_ready is low, and no new request is granted until it is taken.

module and8bit (
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  output logic [7:0] c_o
);
  assign c_o = a_i & b_i;
endmodule

module and8bit_arbiter #(
  parameter int WIDTH = 8,
  parameter int FAIR  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] A0,
  input  logic [WIDTH-1:0] B0,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] A1,
  input  logic [WIDTH-1:0] B1,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] C,
  output logic             busy
);

  if (WIDTH != 8) begin : g_width_check
    $error("and8bit_arbiter: WIDTH must be 8");
  end

  localparam logic FAIR_EN = (FAIR != 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] c_q, c_d;
  logic             id_q, id_d;
  logic             last_grant_q, last_grant_d;
  logic             grant0, grant1;
  logic [WIDTH-1:0] and_res;

  and8bit u_and8bit (
    .a_i (opa_q),
    .b_i (opb_q),
    .c_o (and_res)
  );

  always_comb begin
    state_d      = state_q;
    opa_d        = opa_q;
    opb_d        = opb_q;
    c_d          = c_q;
    id_d         = id_q;
    last_grant_d = last_grant_q;
    grant0       = 1'b0;
    grant1       = 1'b0;
    case (state_q)
      IDLE: begin
        // Port 0 wins unless port 1 also asks and port 0 was served last (fair mode only).
        grant0 = req0_valid & (~req1_valid | ~FAIR_EN | last_grant_q);
        grant1 = req1_valid & ~grant0;
        if (grant0 | grant1) begin
          opa_d   = grant0 ? A0 : A1;
          opb_d   = grant0 ? B0 : B1;
          id_d    = grant1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        c_d     = and_res;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          last_grant_d = id_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      opa_q        <= '0;
      opb_q        <= '0;
      c_q          <= '0;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      opa_q        <= opa_d;
      opb_q        <= opb_d;
      c_q          <= c_d;
      id_q         <= id_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Readies are combinational from the request valids, so mask them while reset is held.
  assign req0_ready = grant0 & rst_n;
  assign req1_ready = grant1 & rst_n;
  assign rsp_valid  = (state_q == RESP);
  assign rsp_id     = id_q;
  assign C          = c_q;
  assign busy       = (state_q != IDLE);

endmodule
